// File: rtl/channel_arbiter_pkg.sv
// Shared types and default sizing for the round-robin channel arbiter.
package channel_arbiter_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_e;

endpackage

// File: rtl/channel_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NUM_REQ.
module rr_pick
  import channel_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W:0]       sum;

  always_comb begin
    dbl   = {req, req};
    rot   = dbl[ptr +: NUM_REQ];
    found = |rot;
    sum   = '0;
    // Walk downward so the lowest rotated offset wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      end
    end
    if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
      sum = sum - (IDX_W + 1)'(NUM_REQ);
    end
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/channel_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ en/ack requesters onto one shared en/ack channel.
// Optional CHANNEL_ARBITER_SRC_ID_EN adds channel_out_src carrying the granted requester index.
//
// state   | meaning
// IDLE    | channel free; grant the next requester at or after rr_ptr
// SEND    | word presented on the channel, waiting for channel_out_ack
module channel_arbiter
  import channel_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_en,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [DATA_WIDTH-1:0]         channel_out_data,
  output logic                          channel_out_en,
  input  logic                          channel_out_ack
`ifdef CHANNEL_ARBITER_SRC_ID_EN
  ,
  output logic [$clog2(NUM_REQ)-1:0]    channel_out_src
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   en_q, en_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req   (req_en),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    en_d    = en_q;
    ack_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          data_d  = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          en_d    = 1'b1;
          ack_d   = NUM_REQ'(1) << pick_idx;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // The first SEND cycle (req_ack still high) is the mandatory wait cycle.
        if (channel_out_ack && (ack_q == '0)) begin
          en_d    = 1'b0;
          ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ack          = ack_q;
  assign channel_out_data = data_q;
  assign channel_out_en   = en_q;

`ifdef CHANNEL_ARBITER_SRC_ID_EN
  assign channel_out_src = grant_q;
`endif

endmodule

// File: tb/tb_channel_arbiter.sv
// Scoreboard bench for channel_arbiter: stimulus queues expected grants, a monitor checks each presented word.
module tb_channel_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_en;
  logic [N-1:0]    req_ack;
  logic [DW-1:0]   channel_out_data;
  logic            channel_out_en;
  logic            channel_out_ack;
`ifdef CHANNEL_ARBITER_SRC_ID_EN
  logic [1:0]      channel_out_src;
`endif

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         ds_delay = 1;
  int         ds_cnt = 0;
  logic [N-1:0] req_hold = '0;
  int         cyc = 0;
  bit         period_chk = 1'b0;
  int         last_grant = -1;

  channel_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_data         (req_data),
    .req_en           (req_en),
    .req_ack          (req_ack),
    .channel_out_data (channel_out_data),
    .channel_out_en   (channel_out_en),
    .channel_out_ack  (channel_out_ack)
`ifdef CHANNEL_ARBITER_SRC_ID_EN
    ,
    .channel_out_src  (channel_out_src)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic expect_word(input int i, input logic [DW-1:0] v);
    exp_t e;
    e.idx  = i;
    e.data = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && !channel_out_en && req_en == '0) && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    check({name, "_drained"}, 64'(t < budget), 64'd1);
  endtask

  task automatic wait_grant(input string name, input logic [N-1:0] want);
    int t;
    t = 0;
    while (req_ack == '0 && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    check({name, "_grant"}, 64'(req_ack), 64'(want));
  endtask

  // Monitor: every new grant (req_ack pulse) must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (req_ack != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 64'(req_ack), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("grant_idx", 64'(req_ack), 64'd1 << e.idx);
          check("grant_data", 64'(channel_out_data), 64'(e.data));
          check("grant_en", 64'(channel_out_en), 64'd1);
`ifdef CHANNEL_ARBITER_SRC_ID_EN
          check("grant_src", 64'(channel_out_src), 64'(e.idx));
`endif
        end
        if (period_chk) begin
          if (last_grant >= 0) check("grant_period", 64'(cyc - last_grant), 64'd3);
          last_grant = cyc;
        end
      end
    end
  end

  // Downstream: ack pulse ds_delay cycles after en is first seen.
  initial begin
    channel_out_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (channel_out_ack) begin
        channel_out_ack = 1'b0;
      end else if (channel_out_en && !rst) begin
        if (ds_cnt >= ds_delay) begin
          channel_out_ack = 1'b1;
          ds_cnt = 0;
        end else begin
          ds_cnt++;
        end
      end else begin
        ds_cnt = 0;
      end
    end
  end

  // Requesters drop en after sampling their ack, unless held for continuous traffic.
  initial begin
    logic [N-1:0] seen;
    forever begin
      @(negedge clk);
      seen = req_ack;
      @(posedge clk);
      #1;
      req_en = req_en & ~(seen & ~req_hold);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hi;
    int t;
    rst      = 1'b1;
    req_en   = '0;
    req_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_en", 64'(channel_out_en), 64'd0);
    check("rst_data", 64'(channel_out_data), 64'd0);
    check("rst_ack", 64'(req_ack), 64'd0);
    rst = 1'b0;

    // single requester on index 2
    ds_delay = 3;
    @(negedge clk);
    set_data(2, 32'd123);
    req_en[2] = 1'b1;
    expect_word(2, 32'd123);
    @(negedge clk);
    #1;
    check("t1_ack_pulse", 64'(req_ack), 64'b0100);
    hi = 0;
    for (int k = 0; k < 50 && channel_out_en; k++) begin
      hi++;
      check("t1_data_hold", 64'(channel_out_data), 64'd123);
      if (k == 1) check("t1_ack_one_cycle", 64'(req_ack), 64'd0);
      @(negedge clk);
      #1;
    end
    check("t1_en_cycles", 64'(hi), 64'd4);
    wait_drain("t1", 50);

    // continuous requests on all four from a fresh pointer
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ds_delay = 1;
    for (int i = 0; i < N; i++) set_data(i, 32'(10 + i));
    for (int k = 0; k < 8; k++) expect_word(k % N, 32'(10 + (k % N)));
    req_hold   = '1;
    period_chk = 1'b1;
    last_grant = -1;
    req_en     = '1;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("t2_all_served", 64'(exp_q.size()), 64'd0);
    req_en     = '0;
    req_hold   = '0;
    period_chk = 1'b0;
    wait_drain("t2", 50);

    // move pointer to 3, then requests on 1 and 3 must wrap 3 -> 1
    set_data(2, 32'h22);
    req_en[2] = 1'b1;
    expect_word(2, 32'h22);
    wait_drain("t3a", 50);
    set_data(1, 32'd201);
    set_data(3, 32'd203);
    expect_word(3, 32'd203);
    expect_word(1, 32'd201);
    req_en[1] = 1'b1;
    req_en[3] = 1'b1;
    wait_drain("t3b", 50);

    // downstream ack held off for 20 cycles; a new request must wait
    ds_delay = 20;
    set_data(0, 32'hAA);
    req_en[0] = 1'b1;
    expect_word(0, 32'hAA);
    wait_grant("t4", 4'b0001);
    set_data(3, 32'd77);
    req_en[3] = 1'b1;
    expect_word(3, 32'd77);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      #1;
      check("t4_data_stable", 64'(channel_out_data), 64'hAA);
      check("t4_en_held", 64'(channel_out_en), 64'd1);
      check("t4_no_ack", 64'(req_ack), 64'd0);
    end
    wait_drain("t4", 100);

    // reset during SEND discards the transfer and clears the pointer
    ds_delay = 1;
    set_data(1, 32'h11);
    req_en[1] = 1'b1;
    expect_word(1, 32'h11);
    wait_drain("t5a", 50);
    ds_delay = 10;
    set_data(3, 32'h33);
    req_en[3] = 1'b1;
    expect_word(3, 32'h33);
    wait_grant("t5", 4'b1000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_en", 64'(channel_out_en), 64'd0);
    check("t5_rst_data", 64'(channel_out_data), 64'd0);
    check("t5_rst_ack", 64'(req_ack), 64'd0);
    rst = 1'b0;
    ds_delay = 1;
    set_data(1, 32'h41);
    set_data(3, 32'h43);
    expect_word(1, 32'h41);
    expect_word(3, 32'h43);
    req_en[1] = 1'b1;
    req_en[3] = 1'b1;
    wait_drain("t5b", 50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/channel_arbiter.md
CHANNEL_ARBITER -- requirements
Module: channel_arbiter

Interface
REQ-001 The block SHALL have the parameter NUM_REQ, default 4, giving the number of requester channels (2..8).
REQ-002 The block SHALL have the parameter DATA_WIDTH, default 32, giving the channel data width.
REQ-003 The block SHALL have the port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit, the reset, which is synchronous and active-high.
REQ-005 The block SHALL have the port req_data, input, NUM_REQ*DATA_WIDTH bits, requester i's data in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 The block SHALL have the port req_en, input, NUM_REQ bits, requester i holding valid data.
REQ-007 The block SHALL have the port req_ack, output, NUM_REQ bits, a one-cycle accept pulse to requester i.
REQ-008 The block SHALL have the port channel_out_data, output, DATA_WIDTH bits, the shared channel data.
REQ-009 The block SHALL have the port channel_out_en, output, 1 bit, shared channel data valid.
REQ-010 The block SHALL have the port channel_out_ack, input, 1 bit, the downstream accept pulse.

Function
REQ-011 The block SHALL use the en/ack handshake on every channel: the sender holds en and data stable until it samples ack=1, then drops en; ack is a single-cycle pulse.
REQ-012 The block SHALL implement the FSM states IDLE and SEND, all outputs registered.
REQ-013 In IDLE with any req_en set, the block SHALL grant at that edge the first requester at or after rr_ptr (modulo NUM_REQ), latch its data into channel_out_data, set channel_out_en=1 and req_ack[grant]=1, and enter SEND.
REQ-014 req_ack SHALL be one-hot or zero, high for exactly the first SEND cycle only.
REQ-015 In SEND, channel_out_en and channel_out_data SHALL stay constant; req_en changes SHALL be ignored.
REQ-016 On sampling channel_out_ack=1 in SEND, the block SHALL clear channel_out_en, set rr_ptr to (grant+1) mod NUM_REQ, and return to IDLE.
REQ-017 The block SHALL ignore channel_out_ack while in IDLE.
REQ-018 The minimum transfer period SHALL be 3 cycles: grant, at least one wait cycle, ack, then IDLE able to grant at the next edge.
REQ-019 When all NUM_REQ requesters request continuously, the grants SHALL rotate strictly, with no requester served twice before every other requester is served once.
REQ-020 rr_ptr SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-021 While rst=1 at an edge, the block SHALL set state IDLE, rr_ptr=0, req_ack=0, channel_out_en=0 and channel_out_data=0.
REQ-022 A reset during SEND SHALL discard the transfer without retry, and channel_out_en SHALL be low in the cycle after the reset edge.

Configuration
REQ-023 With CHANNEL_ARBITER_SRC_ID_EN defined, the block SHALL add the output port channel_out_src, $clog2(NUM_REQ) bits, equal to the granted index, registered with channel_out_data and reset to 0.
REQ-024 Without CHANNEL_ARBITER_SRC_ID_EN, the channel_out_src port and its logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-025 The package channel_arbiter_pkg SHALL hold the FSM state enum and the default NUM_REQ/DATA_WIDTH constants.
REQ-026 The round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector and pointer; outputs: found flag and index), instantiated once.

Verification
REQ-027 The bench SHALL check a single requester: req_en[2]=1 with data 123 -> req_ack[2] pulses 1 cycle later, then channel_out_data=123 and channel_out_en=1 until channel_out_ack.
REQ-028 The bench SHALL check continuous requests on all 4 requesters with data 10/11/12/13 -> outputs in the order 10, 11, 12, 13, 10, ...
REQ-029 The bench SHALL check a pointer at 3 with requests on 1 and 3 -> grant 3 first, then 1 (wrap).
REQ-030 The bench SHALL check a downstream ack held off for 20 cycles -> channel_out_data stable, no extra req_ack, and new req_en ignored.
REQ-031 The bench SHALL check rst asserted in SEND -> channel_out_en=0 next cycle, rr_ptr=0, and the next grant goes to the lowest requesting index.
REQ-032 The bench SHALL check builds with CHANNEL_ARBITER_SRC_ID_EN -> channel_out_src matches the requester index of each output word.
